lock_sequencer: RTL and testbench

Top-level sequencer for the digital lock. It collects keypad digits into an entry buffer, checks the entry against a stored code on submit, and drives unlock/fail indications. It counts consecutive failures and enforces a timed lockout, auto-relocks after a fixed open window, and lets the user program a new code while unlocked. It sits between the keypad debouncer/decoder and the front-panel LEDs, and owns the stored code register.

---
 rtl/lock_sequencer.sv | 179 +++++++++++++++++
 tb/tb_lock_sequencer.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/lock_sequencer.sv
// Digital lock sequencer: keypad entry buffer, code check, fail/lockout timing,
// auto-relock and in-session code programming.
module lock_sequencer #(
  parameter int DIGITS         = 4,
  parameter int DIGIT_W        = 4,
  parameter logic [DIGITS*DIGIT_W-1:0] DEFAULT_CODE = 16'h1234,
  parameter int MAX_FAILS      = 3,
  parameter int FAIL_CYCLES    = 4,
  parameter int UNLOCK_CYCLES  = 10,
  parameter int LOCKOUT_CYCLES = 20
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         key_valid,
  input  logic [DIGIT_W-1:0]           key_digit,
  input  logic                         key_clear,
  input  logic                         submit,
  input  logic                         set_code,
  output logic                         unlock_led,
  output logic                         fail_led,
  output logic                         lockout_led,
  output logic                         ready_for_input,
  output logic [$clog2(DIGITS+1)-1:0]  entry_count
);

  // state     | meaning
  // S_IDLE    | collecting digits for an unlock attempt
  // S_CHECK   | one-cycle compare of entry against stored code
  // S_UNLOCKED| lock open, relocks when the timer expires
  // S_FAIL    | wrong-code indication, inputs ignored
  // S_LOCKOUT | too many consecutive failures, inputs ignored
  // S_PROGRAM | collecting a new code while open
  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_UNLOCKED, S_FAIL, S_LOCKOUT, S_PROGRAM
  } state_t;

  localparam int CODE_W = DIGITS * DIGIT_W;
  localparam int CW     = $clog2(DIGITS + 1);
  localparam int FW     = $clog2(MAX_FAILS + 1);
  localparam int TMAX_A = (FAIL_CYCLES > UNLOCK_CYCLES) ? FAIL_CYCLES : UNLOCK_CYCLES;
  localparam int TMAX   = (TMAX_A > LOCKOUT_CYCLES) ? TMAX_A : LOCKOUT_CYCLES;
  localparam int TW     = $clog2(TMAX + 1);

  state_t              state_q, state_d;
  logic [CODE_W-1:0]   buf_q, buf_d;
  logic [CW-1:0]       count_q, count_d;
  logic [FW-1:0]       fails_q, fails_d;
  logic [CODE_W-1:0]   code_q, code_d;
  logic [TW-1:0]       timer_q, timer_d;

  logic                full;
  logic                take_key;
  logic [CODE_W-1:0]   shifted;

  assign full     = (count_q == CW'(DIGITS));
  assign take_key = key_valid && !full;
  assign shifted  = (buf_q << DIGIT_W) | CODE_W'(key_digit);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      buf_q   <= '0;
      count_q <= '0;
      fails_q <= '0;
      code_q  <= DEFAULT_CODE;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      count_q <= count_d;
      fails_q <= fails_d;
      code_q  <= code_d;
      timer_q <= timer_d;
    end
  end

  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    count_d = count_q;
    fails_d = fails_q;
    code_d  = code_q;
    timer_d = timer_q;
    case (state_q)
      S_IDLE: begin
        if (key_clear) begin
          buf_d   = '0;
          count_d = '0;
        end else if (submit && full) begin
          state_d = S_CHECK;
        end else if (take_key) begin
          buf_d   = shifted;
          count_d = count_q + 1'b1;
        end
      end
      S_CHECK: begin
        buf_d   = '0;
        count_d = '0;
        if (buf_q == code_q) begin
          state_d = S_UNLOCKED;
          fails_d = '0;
          timer_d = TW'(UNLOCK_CYCLES - 1);
        end else if (fails_q == FW'(MAX_FAILS - 1)) begin
          state_d = S_LOCKOUT;
          timer_d = TW'(LOCKOUT_CYCLES - 1);
        end else begin
          state_d = S_FAIL;
          fails_d = fails_q + 1'b1;
          timer_d = TW'(FAIL_CYCLES - 1);
        end
      end
      S_UNLOCKED: begin
        if (key_clear || timer_q == '0) begin
          state_d = S_IDLE;
        end else if (set_code) begin
          state_d = S_PROGRAM;
          timer_d = TW'(UNLOCK_CYCLES - 1);
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      S_FAIL: begin
        if (timer_q == '0) state_d = S_IDLE;
        else               timer_d = timer_q - 1'b1;
      end
      S_LOCKOUT: begin
        if (timer_q == '0) begin
          state_d = S_IDLE;
          fails_d = '0;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      S_PROGRAM: begin
        if (key_clear || timer_q == '0) begin
          state_d = S_IDLE;
          buf_d   = '0;
          count_d = '0;
        end else if (submit && full) begin
          state_d = S_IDLE;
          code_d  = buf_q;
          buf_d   = '0;
          count_d = '0;
        end else begin
          timer_d = timer_q - 1'b1;
          if (take_key) begin
            buf_d   = shifted;
            count_d = count_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    unlock_led      = 1'b0;
    fail_led        = 1'b0;
    lockout_led     = 1'b0;
    ready_for_input = 1'b0;
    case (state_q)
      S_IDLE:     ready_for_input = 1'b1;
      S_UNLOCKED: unlock_led = 1'b1;
      S_PROGRAM: begin
        unlock_led      = 1'b1;
        ready_for_input = 1'b1;
      end
      S_FAIL:     fail_led = 1'b1;
      S_LOCKOUT: begin
        fail_led    = 1'b1;
        lockout_led = 1'b1;
      end
      default: ;
    endcase
  end

  assign entry_count = count_q;

endmodule

// File: tb/tb_lock_sequencer.sv
// Randomised + directed bench for lock_sequencer; a queue-based reference model
// predicts the outputs after every edge and a monitor compares them.
module tb_lock_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       key_valid = 1'b0;
  logic [3:0] key_digit = '0;
  logic       key_clear = 1'b0;
  logic       submit = 1'b0;
  logic       set_code = 1'b0;
  logic       unlock_led, fail_led, lockout_led, ready_for_input;
  logic [2:0] entry_count;

  lock_sequencer dut (
    .clk(clk), .rst(rst), .key_valid(key_valid), .key_digit(key_digit),
    .key_clear(key_clear), .submit(submit), .set_code(set_code),
    .unlock_led(unlock_led), .fail_led(fail_led), .lockout_led(lockout_led),
    .ready_for_input(ready_for_input), .entry_count(entry_count)
  );

  always #5 clk = ~clk;

  // Model: which mode we are in, digits entered, stored code, failures,
  // and how many cycles have been spent in the current timed mode.
  typedef enum {M_IDLE, M_CHECK, M_UNLOCKED, M_FAIL, M_LOCKOUT, M_PROGRAM} mode_t;
  mode_t       m_mode = M_IDLE;
  int          m_digs[$];
  logic [15:0] m_code = 16'h1234;
  int          m_fails = 0;
  int          m_spent = 0;

  logic [6:0]  exp_q[$];
  int          n_tests = 0;
  int          n_fail = 0;
  int          cyc = 0;

  function automatic logic [15:0] entry_value();
    logic [15:0] v = '0;
    foreach (m_digs[i]) v = (v << 4) | 16'(m_digs[i]);
    return v;
  endfunction

  function automatic logic [6:0] predicted();
    logic u = (m_mode == M_UNLOCKED) || (m_mode == M_PROGRAM);
    logic f = (m_mode == M_FAIL) || (m_mode == M_LOCKOUT);
    logic l = (m_mode == M_LOCKOUT);
    logic r = (m_mode == M_IDLE) || (m_mode == M_PROGRAM);
    return {u, f, l, r, 3'(m_digs.size())};
  endfunction

  task automatic enter_mode(input mode_t m);
    m_mode  = m;
    m_spent = 1;
  endtask

  task automatic model_step(input logic r, kv, input logic [3:0] kd,
                            input logic kc, sb, sc);
    bit full = (m_digs.size() == 4);
    if (r) begin
      m_mode = M_IDLE; m_digs.delete(); m_code = 16'h1234; m_fails = 0; m_spent = 0;
      return;
    end
    case (m_mode)
      M_IDLE: begin
        if (kc) m_digs.delete();
        else if (sb && full) m_mode = M_CHECK;
        else if (kv && !full) m_digs.push_back(int'(kd));
      end
      M_CHECK: begin
        logic [15:0] v = entry_value();
        m_digs.delete();
        if (v == m_code) begin
          m_fails = 0; enter_mode(M_UNLOCKED);
        end else if (m_fails + 1 == 3) begin
          enter_mode(M_LOCKOUT);
        end else begin
          m_fails++; enter_mode(M_FAIL);
        end
      end
      M_UNLOCKED: begin
        if (kc || m_spent == 10) m_mode = M_IDLE;
        else if (sc) enter_mode(M_PROGRAM);
        else m_spent++;
      end
      M_FAIL: begin
        if (m_spent == 4) m_mode = M_IDLE; else m_spent++;
      end
      M_LOCKOUT: begin
        if (m_spent == 20) begin m_mode = M_IDLE; m_fails = 0; end
        else m_spent++;
      end
      M_PROGRAM: begin
        if (kc || m_spent == 10) begin
          m_mode = M_IDLE; m_digs.delete();
        end else if (sb && full) begin
          m_code = entry_value(); m_digs.delete(); m_mode = M_IDLE;
        end else begin
          m_spent++;
          if (kv && !full) m_digs.push_back(int'(kd));
        end
      end
      default: m_mode = M_IDLE;
    endcase
  endtask

  task automatic step(input logic r, kv, input logic [3:0] kd,
                      input logic kc, sb, sc);
    @(negedge clk);
    rst = r; key_valid = kv; key_digit = kd; key_clear = kc; submit = sb; set_code = sc;
    model_step(r, kv, kd, kc, sb, sc);
    exp_q.push_back(predicted());
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 4'h0, 0, 0, 0);
  endtask

  task automatic key(input logic [3:0] d);
    step(0, 1, d, 0, 0, 0);
  endtask

  task automatic enter(input logic [15:0] c);
    for (int i = 3; i >= 0; i--) begin
      logic [15:0] t = c >> (4 * i);
      key(t[3:0]);
    end
  endtask

  task automatic attempt(input logic [15:0] c, input int wait_n);
    enter(c);
    step(0, 0, 4'h0, 0, 1, 0);
    idle(wait_n);
  endtask

  // Monitor: one prediction per edge, compared one time unit after that edge.
  initial begin
    logic [6:0] e, a;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = {unlock_led, fail_led, lockout_led, ready_for_input, entry_count};
        n_tests++;
        if (a !== e) begin
          n_fail++;
          $display("FAIL outputs cycle %0d: got unl/fail/lock/rdy/cnt=%b/%b/%b/%b/%0d required %b/%b/%b/%b/%0d",
                   cyc, a[6], a[5], a[4], a[3], a[2:0], e[6], e[5], e[4], e[3], e[2:0]);
        end
      end
    end
  end

  initial begin
    step(1, 0, 4'h0, 0, 0, 0);
    step(1, 0, 4'h0, 0, 0, 0);
    idle(2);
    // correct, wrong, then correct again
    attempt(16'h1234, 13);
    attempt(16'h1235, 6);
    attempt(16'h1234, 12);
    // three wrong entries in a row, keys during lockout
    attempt(16'h9999, 6);
    attempt(16'h1111, 6);
    attempt(16'h0000, 2);
    for (int i = 0; i < 8; i++) step(0, 1, 4'h1, i[0], i[1], 1);
    idle(14);
    attempt(16'h1234, 12);
    // buffer edges
    enter(16'h1234); key(4'h9);
    step(0, 0, 4'h0, 0, 1, 0); idle(12);
    key(4'h1); key(4'h2); key(4'h3);
    step(0, 0, 4'h0, 0, 1, 0); idle(2);
    key(4'h4);
    step(0, 0, 4'h0, 1, 1, 0); idle(2);
    step(0, 1, 4'h7, 0, 1, 0); idle(2);
    // programming a new code
    attempt(16'h1234, 2);
    step(0, 0, 4'h0, 0, 0, 1);
    enter(16'h5678);
    step(0, 0, 4'h0, 0, 1, 0); idle(2);
    attempt(16'h1234, 6);
    attempt(16'h5678, 2);
    // aborted session
    step(0, 0, 4'h0, 0, 0, 1);
    enter(16'h4321);
    step(0, 0, 4'h0, 1, 1, 0); idle(2);
    attempt(16'h5678, 2);
    // timed-out session, set_code and key_clear together
    step(0, 0, 4'h0, 0, 0, 1);
    key(4'h1); key(4'h1);
    idle(12);
    attempt(16'h5678, 2);
    step(0, 0, 4'h0, 1, 0, 1); idle(2);
    // reset during unlocked and during lockout
    attempt(16'h5678, 3);
    step(1, 0, 4'h0, 0, 0, 0); idle(2);
    attempt(16'h1234, 12);
    attempt(16'h0001, 6); attempt(16'h0002, 6); attempt(16'h0003, 5);
    step(1, 0, 4'h0, 0, 0, 0); idle(2);
    attempt(16'h0004, 6);
    attempt(16'h1234, 12);
    // randomized traffic, biased toward correct digits so every mode is reached
    for (int i = 0; i < 4000; i++) begin
      logic        kv, kc, sb, sc, r;
      logic [3:0]  kd;
      logic [15:0] sh;
      kv = ($urandom % 3) == 0;
      kc = ($urandom % 40) == 0;
      sb = ($urandom % 5) == 0;
      sc = ($urandom % 6) == 0;
      r  = ($urandom % 800) == 0;
      kd = 4'($urandom);
      if (m_digs.size() < 4 && ($urandom % 4) != 0) begin
        sh = m_code >> (4 * (3 - m_digs.size()));
        kd = sh[3:0];
      end
      step(r, kv, kd, kc, sb, sc);
    end
    idle(2);
    @(negedge clk);
    @(negedge clk);
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d predictions left, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
